ps2_key_rx: RTL and testbench

//   Receives PS/2 keyboard frames (device-to-host) on the raw ps2_clk/ps2_data pins and

---
 rtl/ps2_key_rx.sv | 263 ++++++++++++++++++++++++++
 tb/tb_ps2_key_rx.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_rx.sv
// ---------------------------------------------------------------------------
// ps2_key_rx
//   PS/2 keyboard receiver (device-to-host). Synchronises the raw PS/2 clock
//   and data pins, frames 11-bit words (start, 8 data LSB first, odd parity,
//   stop), folds E0/F0 prefix bytes into flags on the following scancode and
//   queues one event per make/break code in a first-word-fall-through FIFO.
//
// Parameters
//   FIFO_DEPTH      event FIFO entries (power of two, >= 2)
//   TIMEOUT_CYCLES  clk cycles without a ps2_clk falling edge before a
//                   partial frame is abandoned
//
// Ports
//   clk        system clock, all logic on posedge
//   rst        asynchronous active-high reset
//   ps2_clk    raw PS/2 clock pin (asynchronous)
//   ps2_data   raw PS/2 data pin (asynchronous)
//   key_valid  FIFO non-empty; head event on key_code/key_ext/key_brk
//   key_ready  consumer accepts the head event when key_valid is high
//   key_code   scancode of the head event
//   key_ext    head event was preceded by E0
//   key_brk    head event was preceded by F0 (key release)
//   frame_err  one-cycle pulse: bad start/parity/stop bit or timeout abort
//   overflow   one-cycle pulse: completed event dropped, FIFO full
// ---------------------------------------------------------------------------
module ps2_key_rx #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_valid,
    input  logic       key_ready,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_brk,
    output logic       frame_err,
    output logic       overflow
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    // -----------------------------------------------------------------------
    // Input synchronisers; a third clock stage gives the falling-edge detect
    // -----------------------------------------------------------------------
    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic dat_meta_q, dat_sync_q;
    logic fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            clk_prev_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= ps2_clk;
            clk_sync_q <= clk_meta_q;
            clk_prev_q <= clk_sync_q;
            dat_meta_q <= ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    assign fall = clk_prev_q & ~clk_sync_q;

    // -----------------------------------------------------------------------
    // Frame FSM
    // -----------------------------------------------------------------------
    state_t          state_q, state_d;
    logic [2:0]      bitcnt_q, bitcnt_d;
    logic [7:0]      shreg_q, shreg_d;
    logic            par_ok_q, par_ok_d;
    logic [TW-1:0]   tcnt_q, tcnt_d;
    logic            err_d;
    logic            done_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            bitcnt_q <= '0;
            shreg_q  <= '0;
            par_ok_q <= 1'b0;
            tcnt_q   <= '0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            shreg_q  <= shreg_d;
            par_ok_q <= par_ok_d;
            tcnt_q   <= tcnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        shreg_d  = shreg_q;
        par_ok_d = par_ok_q;
        tcnt_d   = tcnt_q;
        err_d    = 1'b0;
        done_d   = 1'b0;

        if (fall) begin
            tcnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (!dat_sync_q) begin
                        state_d  = S_DATA;
                        bitcnt_d = '0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                S_DATA: begin
                    shreg_d  = {dat_sync_q, shreg_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    // odd parity across data + parity bit
                    par_ok_d = (dat_sync_q == ~^shreg_q);
                    state_d  = S_STOP;
                end
                S_STOP: begin
                    if (dat_sync_q && par_ok_q) begin
                        done_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (tcnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
                state_d = S_IDLE;
                tcnt_d  = '0;
                err_d   = 1'b1;
            end else begin
                tcnt_d = tcnt_q + TW'(1);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Decode stage: completed byte registered, then prefix folding
    // -----------------------------------------------------------------------
    logic       byte_vld_q;
    logic [7:0] byte_q;
    logic       frame_err_q;
    logic       ext_pend_q, ext_pend_d;
    logic       brk_pend_q, brk_pend_d;
    logic       push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            byte_vld_q  <= 1'b0;
            byte_q      <= '0;
            frame_err_q <= 1'b0;
            ext_pend_q  <= 1'b0;
            brk_pend_q  <= 1'b0;
        end else begin
            byte_vld_q  <= done_d;
            byte_q      <= shreg_q;
            frame_err_q <= err_d;
            ext_pend_q  <= ext_pend_d;
            brk_pend_q  <= brk_pend_d;
        end
    end

    always_comb begin
        ext_pend_d = ext_pend_q;
        brk_pend_d = brk_pend_q;
        push       = 1'b0;

        if (byte_vld_q) begin
            if (byte_q == 8'hE0) begin
                ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
                brk_pend_d = 1'b1;
            end else begin
                push       = 1'b1;
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end
        // an error anywhere in the byte stream invalidates pending prefixes
        if (err_d) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Event FIFO, first-word-fall-through
    // -----------------------------------------------------------------------
    logic [9:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full, pop, wr_en, ovf_d;
    logic          overflow_q;
    logic [9:0]    head;

    assign full  = (count_q == CW'(FIFO_DEPTH));
    assign pop   = (count_q != '0) && key_ready;
    // a pop frees the slot in the same cycle, so a full FIFO still accepts
    assign wr_en = push && (!full || pop);
    assign ovf_d = push && full && !pop;

    always_comb begin
        count_d = count_q;
        unique case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= {ext_pend_q, brk_pend_q, byte_q};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q    <= count_d;
            overflow_q <= ovf_d;
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign key_valid = (count_q != '0);
    assign key_code  = head[7:0];
    assign key_brk   = head[8];
    assign key_ext   = head[9];
    assign frame_err = frame_err_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: randomised PS/2 frames, a byte-level reference model
// (prefix folding + bounded event queue) feeding a scoreboard, and a monitor
// that pops and compares on every handshake.
module tb_ps2_key_rx;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 300;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_valid;
    logic       key_ready = 1'b0;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_brk;
    logic       frame_err;
    logic       overflow;

    ps2_key_rx #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_code  (key_code),
        .key_ext   (key_ext),
        .key_brk   (key_brk),
        .frame_err (frame_err),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    ev_t exp_q[$];
    int  checks  = 0;
    int  errors  = 0;
    int  exp_err = 0;
    int  exp_ovf = 0;
    int  err_cnt = 0;
    int  ovf_cnt = 0;
    bit  m_ext   = 1'b0;
    bit  m_brk   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample mid-cycle, away from the active edge
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err) err_cnt++;
            if (overflow)  ovf_cnt++;
            if (key_valid && key_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: got code %0h ext %0b brk %0b expected none",
                             key_code, key_ext, key_brk);
                end else begin
                    ev_t e;
                    e = exp_q.pop_front();
                    check("event", {21'd0, key_ext, key_brk, key_code}, {21'd0, e.ext, e.brk, e.code});
                end
            end
        end
    end

    // Reference model at the byte level
    task automatic model_frame(input logic [7:0] b, input bit bad, input bit bonus);
        if (bad) begin
            exp_err++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (exp_q.size() < DEPTH || bonus) exp_q.push_back('{code: b, ext: m_ext, brk: m_brk});
            else exp_ovf++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic half();
        repeat ($urandom_range(4, 9)) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1 key_ready = v;
    endtask

    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Full frame; nbits < 11 gives a truncated frame with no model update
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                              input bit bonus, input int nbits);
        logic [10:0] fr;
        fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = fr[i];
            half();
            ps2_clk = 1'b0;
            if (i == 10) begin
                model_frame(b, bad_par || bad_stop, bonus);
                if (bonus) begin
                    // one-cycle pop aligned with the write of this event
                    fork
                        begin
                            repeat (3) @(posedge clk);
                            #1 key_ready = 1'b1;
                            @(posedge clk);
                            #1 key_ready = 1'b0;
                        end
                    join_none
                end
            end
            half();
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        half();
    endtask

    task automatic send(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b0, 1'b0, 11);
    endtask

    task automatic stray_edge();
        ps2_data = 1'b1;
        half();
        ps2_clk = 1'b0;
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        half();
        ps2_clk = 1'b1;
        half();
    endtask

    task automatic checkpoint(input string name);
        settle(40);
        check({name, "_frame_err"}, err_cnt, exp_err);
        check({name, "_overflow"}, ovf_cnt, exp_ovf);
        if (key_ready) check({name, "_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        settle(3);
        check("rst_valid", key_valid, 0);
        check("rst_code", key_code, 0);
        check("rst_ext", key_ext, 0);
        check("rst_brk", key_brk, 0);
        check("rst_err", frame_err, 0);
        check("rst_ovf", overflow, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        settle(5);

        set_ready(1'b1);
        send(8'h1C);
        checkpoint("t1");

        send(8'hE0);
        send(8'h75);
        checkpoint("t2");

        send(8'hE0); send(8'hF0); send(8'h75);
        send(8'hF0); send(8'h1C);
        checkpoint("t3");

        send_frame(8'h1C, 1'b1, 1'b0, 1'b0, 11);
        checkpoint("t4_bad");
        send(8'h1C);
        checkpoint("t4_good");

        send(8'hF0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 5);
        exp_err++;
        m_ext = 1'b0;
        m_brk = 1'b0;
        settle(TIMEOUT + 100);
        checkpoint("t5_timeout");
        send(8'hE0);
        send(8'h75);
        checkpoint("t5_after");

        set_ready(1'b0);
        send(8'h11); send(8'h22); send(8'h33); send(8'h44); send(8'h55);
        checkpoint("t6_full");
        check("t6_valid", key_valid, 1);
        set_ready(1'b1);
        settle(20);
        check("t6_empty_q", exp_q.size(), 0);
        check("t6_valid_low", key_valid, 0);

        set_ready(1'b0);
        send(8'hA1); send(8'hA2); send(8'hA3); send(8'hA4);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 11);
        checkpoint("bonus");
        check("bonus_left", exp_q.size(), DEPTH);
        check("bonus_valid", key_valid, 1);
        set_ready(1'b1);
        settle(20);
        check("bonus_empty", exp_q.size(), 0);
        check("bonus_valid_low", key_valid, 0);

        set_ready(1'b0);
        send(8'h2B); send(8'hE0); send(8'h3C);
        @(posedge clk);
        #1 rst = 1'b1;
        settle(3);
        check("midrst_valid", key_valid, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        set_ready(1'b1);
        send(8'h66);
        checkpoint("post_rst");

        for (int n = 0; n < 30; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            case (kind)
                0, 1: send(8'hE0);
                2:    send(8'hF0);
                3:    send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0, 1'b0, 11);
                4:    send_frame(8'($urandom_range(0, 255)), 1'b0, 1'b1, 1'b0, 11);
                5:    stray_edge();
                default: send(8'($urandom_range(0, 255)));
            endcase
        end
        checkpoint("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
